res_station: RTL and testbench
==============================

Name: res_station

Overview:
- Reservation station for one functional-unit class: add/sub, multiply or divide.
- Sits directly downstream of the decode/control unit. Its ResStationEN bit drives issue_en, its ALUop drives issue_op, and it reads back this block's isFull.
- Holds issued instructions, snoops the common data bus (CDB) for pending source operands, and dispatches ready entries to its ALU with a valid/ready handshake.
- Entries are freed when their own result appears on the CDB.

Parameters:
- ENTRIES, 3, number of station entries (1..8).
- DATA_W, 32, operand and CDB data width.
- TAG_W, 4, producer tag width. Tag 0 means "value present, no producer".
- BASE_TAG, 1, tag of entry 0. Entry i owns tag BASE_TAG+i. BASE_TAG must be at least 1.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- nRST  in  1  synchronous active-low reset.
- issue_en  in  1  issue request from the control unit (its ResStationEN bit for this station).
- issue_op  in  2  ALUop for the issued instruction.
- issue_vj  in  DATA_W  source j value; meaningful when issue_qj==0.
- issue_qj  in  TAG_W  source j producer tag.
- issue_vk  in  DATA_W  source k value.
- issue_qk  in  TAG_W  source k producer tag.
- isFull  out  1  no FREE entry; fed back to the control unit.
- issue_tag  out  TAG_W  tag the next issue will receive, for the register status table. Valid whenever isFull==0.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  TAG_W  broadcasting producer tag.
- cdb_data  in  DATA_W  broadcast result.
- exe_valid  out  1  a ready entry is offered to the ALU.
- exe_ready  in  1  ALU accepts this cycle.
- exe_op  out  2  offered op.
- exe_a  out  DATA_W  offered source j value.
- exe_b  out  DATA_W  offered source k value.
- exe_tag  out  TAG_W  offered entry tag; the ALU broadcasts its result with this tag.

Behaviour:
- Each entry has state FREE, BUSY or EXEC, plus registered op, vj, qj, vk, qk.
  - An entry is ready when it is BUSY and qj==0 and qk==0.
- Reset (nRST low at clk edge):
  - All entries FREE; all fields 0.
  - Outputs: isFull=0, exe_valid=0, issue_tag=BASE_TAG.
  - exe_op, exe_a, exe_b and exe_tag read 0.
  - Reset mid-operation discards all entries, including EXEC ones.
  - nRST has priority over every other event.
- isFull and issue_tag are combinational from registered state only.
  - issue_tag = BASE_TAG + index of the lowest FREE entry.
- Issue: on a clk edge with issue_en=1 and isFull=0:
  - The lowest FREE entry becomes BUSY and captures op, vj, qj, vk, qk.
  - If issue_en=1 while isFull=1, the request is ignored with no state change. The control unit is responsible for stalling.
- Issue-time CDB bypass: if cdb_valid and issue_qj==cdb_tag (with issue_qj nonzero), the entry stores vj=cdb_data and qj=0. Same rule for k.
- CDB snoop: on each edge with cdb_valid, every BUSY entry with qj==cdb_tag (qj nonzero) loads vj=cdb_data and qj=0. Same for k; both operands may update in one cycle.
- Free: on a CDB broadcast, an EXEC entry whose own tag equals cdb_tag becomes FREE.
  - The freed slot is visible through isFull/issue_tag in the next cycle. No same-cycle reuse.
  - A CDB tag matching a BUSY entry's own tag is ignored for freeing.
- Dispatch:
  - exe_valid=1 iff any entry is ready. The selected entry is the lowest-index ready one.
  - exe_op, exe_a, exe_b and exe_tag come combinationally from the selected entry.
  - exe_valid must not depend combinationally on exe_ready.
  - On an edge with exe_valid and exe_ready, the selected entry goes BUSY to EXEC.
  - If exe_ready=0, the offer holds unchanged unless a lower-index entry becomes ready.
- Latency:
  - An issue with both operands present gives exe_valid at the earliest in the cycle after the issue edge.
  - An operand completed by the CDB at edge t makes its entry eligible from cycle t+1.
- Simultaneous events in one edge are all applied: issue into entry i, snoop updates in other entries, dispatch of entry j, and free of entry m.

Test Plan:
- Reset, then issue op=0, vj=5, vk=7, qj=qk=0, exe_ready=1 -> next cycle exe_valid=1, exe_a=5, exe_b=7, exe_tag=1. After accept, exe_valid=0 and isFull=0. CDB tag=1 frees entry 0.
- Issue qj=5, vk=3, qk=0. Two cycles later CDB valid with tag=5, data=0x10 -> exe_valid rises the cycle after the broadcast, with exe_a=0x10, exe_b=3.
- Issue three instructions with pending qj=9 -> isFull=1. A fourth issue is ignored. Broadcast tag 9 while exe_ready=1, dispatching entries in order 1,2,3. Then broadcast tag 2 -> isFull=0 next cycle and issue_tag=2.
- Issue with qk=6 in the same cycle as a CDB broadcast of tag=6, data=0xAB -> entry stores vk=0xAB and is offered next cycle.
- Hold exe_ready=0 for 4 cycles with one ready entry -> exe_valid, exe_a and exe_tag stay stable. Raise exe_ready -> accepted once only.
- Fill two entries, one EXEC, then pulse nRST low -> isFull=0, exe_valid=0, issue_tag=1. A later CDB with the old tag has no effect.

Source files
------------

// File: rtl/res_station.sv
`default_nettype none
// ============================================================================
//  Module      : res_station
//  Description : Reservation station for one functional-unit class. Holds
//                issued instructions, snoops the common data bus (CDB) for
//                pending source operands, dispatches the lowest-index ready
//                entry to its ALU with a valid/ready handshake, and frees an
//                entry when its own result tag appears on the CDB.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   system clock, all state updates on rising edge
//    nRST       in   synchronous active-low reset
//    issue_en   in   issue request from the control unit
//    issue_op   in   ALU op of the issued instruction
//    issue_vj/k in   source values (meaningful when matching q is 0)
//    issue_qj/k in   source producer tags (0 = value present)
//    isFull     out  no FREE entry remains
//    issue_tag  out  tag the next issue will receive (valid when !isFull)
//    cdb_valid  in   CDB broadcast valid
//    cdb_tag    in   broadcasting producer tag
//    cdb_data   in   broadcast result
//    exe_valid  out  a ready entry is offered to the ALU
//    exe_ready  in   ALU accepts the offer this cycle
//    exe_op     out  offered op
//    exe_a/b    out  offered source j / k values
//    exe_tag    out  offered entry tag
// ============================================================================
module res_station #(
    parameter int ENTRIES  = 3,
    parameter int DATA_W   = 32,
    parameter int TAG_W    = 4,
    parameter int BASE_TAG = 1
) (
    input  logic              clk,
    input  logic              nRST,

    input  logic              issue_en,
    input  logic [1:0]        issue_op,
    input  logic [DATA_W-1:0] issue_vj,
    input  logic [TAG_W-1:0]  issue_qj,
    input  logic [DATA_W-1:0] issue_vk,
    input  logic [TAG_W-1:0]  issue_qk,
    output logic              isFull,
    output logic [TAG_W-1:0]  issue_tag,

    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,

    output logic              exe_valid,
    input  logic              exe_ready,
    output logic [1:0]        exe_op,
    output logic [DATA_W-1:0] exe_a,
    output logic [DATA_W-1:0] exe_b,
    output logic [TAG_W-1:0]  exe_tag
);

    localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    typedef enum logic [1:0] {
        ST_FREE = 2'd0,
        ST_BUSY = 2'd1,
        ST_EXEC = 2'd2
    } ent_state_e;

    // ------------------------------------------------------------------
    // Entry storage
    // ------------------------------------------------------------------
    ent_state_e        state_q [ENTRIES];
    ent_state_e        state_d [ENTRIES];
    logic [1:0]        op_q    [ENTRIES];
    logic [1:0]        op_d    [ENTRIES];
    logic [DATA_W-1:0] vj_q    [ENTRIES];
    logic [DATA_W-1:0] vj_d    [ENTRIES];
    logic [TAG_W-1:0]  qj_q    [ENTRIES];
    logic [TAG_W-1:0]  qj_d    [ENTRIES];
    logic [DATA_W-1:0] vk_q    [ENTRIES];
    logic [DATA_W-1:0] vk_d    [ENTRIES];
    logic [TAG_W-1:0]  qk_q    [ENTRIES];
    logic [TAG_W-1:0]  qk_d    [ENTRIES];

    logic [TAG_W-1:0]  own_tag [ENTRIES];
    logic [ENTRIES-1:0] ready;

    logic              free_found;
    logic [IDX_W-1:0]  free_idx;
    logic              any_ready;
    logic [IDX_W-1:0]  sel_idx;

    logic              issue_go;
    logic              disp_go;
    logic [DATA_W-1:0] iss_vj;
    logic [TAG_W-1:0]  iss_qj;
    logic [DATA_W-1:0] iss_vk;
    logic [TAG_W-1:0]  iss_qk;

    // ------------------------------------------------------------------
    // Per-entry constant tag and readiness
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
            assign own_tag[gi] = TAG_W'(BASE_TAG + gi);
            assign ready[gi]   = (state_q[gi] == ST_BUSY) &&
                                 (qj_q[gi] == '0) && (qk_q[gi] == '0);
        end
    endgenerate

    // Lowest-index FREE entry (scan downward so the lowest wins)
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (state_q[i] == ST_FREE) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    // Lowest-index ready entry
    always_comb begin
        any_ready = 1'b0;
        sel_idx   = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (ready[i]) begin
                any_ready = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    // Status and dispatch outputs depend on registered state only, so
    // exe_valid never combinationally follows exe_ready.
    assign isFull    = ~free_found;
    assign issue_tag = TAG_W'(BASE_TAG) + TAG_W'(free_idx);

    assign exe_valid = any_ready;
    assign exe_op    = any_ready ? op_q[sel_idx] : 2'b00;
    assign exe_a     = any_ready ? vj_q[sel_idx] : '0;
    assign exe_b     = any_ready ? vk_q[sel_idx] : '0;
    assign exe_tag   = any_ready ? own_tag[sel_idx] : '0;

    assign issue_go = issue_en & free_found;
    assign disp_go  = any_ready & exe_ready;

    // Issue-time bypass: an operand produced on this very edge is captured
    // directly instead of waiting on a broadcast that has already gone by.
    always_comb begin
        iss_vj = issue_vj;
        iss_qj = issue_qj;
        iss_vk = issue_vk;
        iss_qk = issue_qk;
        if (cdb_valid && (issue_qj != '0) && (issue_qj == cdb_tag)) begin
            iss_vj = cdb_data;
            iss_qj = '0;
        end
        if (cdb_valid && (issue_qk != '0) && (issue_qk == cdb_tag)) begin
            iss_vk = cdb_data;
            iss_qk = '0;
        end
    end

    // ------------------------------------------------------------------
    // Next-state: issue, snoop, dispatch and free act on disjoint entry
    // states, so all of them can apply in the same edge.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        vj_d    = vj_q;
        qj_d    = qj_q;
        vk_d    = vk_q;
        qk_d    = qk_q;
        for (int i = 0; i < ENTRIES; i++) begin
            case (state_q[i])
                ST_FREE: begin
                    if (issue_go && (free_idx == IDX_W'(i))) begin
                        state_d[i] = ST_BUSY;
                        op_d[i]    = issue_op;
                        vj_d[i]    = iss_vj;
                        qj_d[i]    = iss_qj;
                        vk_d[i]    = iss_vk;
                        qk_d[i]    = iss_qk;
                    end
                end
                ST_BUSY: begin
                    if (cdb_valid && (qj_q[i] != '0) && (qj_q[i] == cdb_tag)) begin
                        vj_d[i] = cdb_data;
                        qj_d[i] = '0;
                    end
                    if (cdb_valid && (qk_q[i] != '0) && (qk_q[i] == cdb_tag)) begin
                        vk_d[i] = cdb_data;
                        qk_d[i] = '0;
                    end
                    // The selected entry is ready, so its operands are final
                    if (disp_go && (sel_idx == IDX_W'(i))) begin
                        state_d[i] = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (cdb_valid && (cdb_tag == own_tag[i])) begin
                        state_d[i] = ST_FREE;
                    end
                end
                default: begin
                    state_d[i] = ST_FREE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!nRST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                state_q[i] <= ST_FREE;
                op_q[i]    <= '0;
                vj_q[i]    <= '0;
                qj_q[i]    <= '0;
                vk_q[i]    <= '0;
                qk_q[i]    <= '0;
            end
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            vj_q    <= vj_d;
            qj_q    <= qj_d;
            vk_q    <= vk_d;
            qk_q    <= qk_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_res_station.sv
`default_nettype none
// ============================================================================
//  Module      : tb_res_station
//  Description : Self-checking bench for res_station. A behavioural model of
//                the station is advanced on every rising edge and compared
//                with the DUT on every falling edge; directed scenarios add
//                hand-computed literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_res_station;

    localparam int ENTRIES  = 3;
    localparam int DATA_W   = 32;
    localparam int TAG_W    = 4;
    localparam int BASE_TAG = 1;

    logic              clk;
    logic              nRST;
    logic              issue_en;
    logic [1:0]        issue_op;
    logic [DATA_W-1:0] issue_vj;
    logic [TAG_W-1:0]  issue_qj;
    logic [DATA_W-1:0] issue_vk;
    logic [TAG_W-1:0]  issue_qk;
    logic              isFull;
    logic [TAG_W-1:0]  issue_tag;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic              exe_valid;
    logic              exe_ready;
    logic [1:0]        exe_op;
    logic [DATA_W-1:0] exe_a;
    logic [DATA_W-1:0] exe_b;
    logic [TAG_W-1:0]  exe_tag;

    res_station #(
        .ENTRIES (ENTRIES),
        .DATA_W  (DATA_W),
        .TAG_W   (TAG_W),
        .BASE_TAG(BASE_TAG)
    ) dut (
        .clk      (clk),
        .nRST     (nRST),
        .issue_en (issue_en),
        .issue_op (issue_op),
        .issue_vj (issue_vj),
        .issue_qj (issue_qj),
        .issue_vk (issue_vk),
        .issue_qk (issue_qk),
        .isFull   (isFull),
        .issue_tag(issue_tag),
        .cdb_valid(cdb_valid),
        .cdb_tag  (cdb_tag),
        .cdb_data (cdb_data),
        .exe_valid(exe_valid),
        .exe_ready(exe_ready),
        .exe_op   (exe_op),
        .exe_a    (exe_a),
        .exe_b    (exe_b),
        .exe_tag  (exe_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: 0 = free, 1 = waiting/ready, 2 = executing
    // ------------------------------------------------------------------
    int                m_st [ENTRIES];
    logic [1:0]        m_op [ENTRIES];
    logic [DATA_W-1:0] m_vj [ENTRIES];
    logic [TAG_W-1:0]  m_qj [ENTRIES];
    logic [DATA_W-1:0] m_vk [ENTRIES];
    logic [TAG_W-1:0]  m_qk [ENTRIES];

    function automatic int m_first_free();
        for (int i = 0; i < ENTRIES; i++) if (m_st[i] == 0) return i;
        return -1;
    endfunction

    function automatic int m_first_ready();
        for (int i = 0; i < ENTRIES; i++)
            if (m_st[i] == 1 && m_qj[i] == 0 && m_qk[i] == 0) return i;
        return -1;
    endfunction

    function automatic bit cdb_hits(input logic [TAG_W-1:0] q);
        return cdb_valid && (q != 0) && (q == cdb_tag);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < ENTRIES; i++) begin
            m_st[i] = 0; m_op[i] = 0; m_vj[i] = 0; m_qj[i] = 0; m_vk[i] = 0; m_qk[i] = 0;
        end
    endtask

    task automatic model_step();
        int fi;
        int si;
        if (!nRST) begin
            model_clear();
            return;
        end
        fi = m_first_free();
        si = m_first_ready();
        for (int i = 0; i < ENTRIES; i++) begin
            if (m_st[i] == 0) begin
                if (issue_en && i == fi) begin
                    m_st[i] = 1;
                    m_op[i] = issue_op;
                    m_vj[i] = cdb_hits(issue_qj) ? cdb_data : issue_vj;
                    m_qj[i] = cdb_hits(issue_qj) ? '0 : issue_qj;
                    m_vk[i] = cdb_hits(issue_qk) ? cdb_data : issue_vk;
                    m_qk[i] = cdb_hits(issue_qk) ? '0 : issue_qk;
                end
            end else if (m_st[i] == 1) begin
                if (i == si && exe_ready) m_st[i] = 2;
                if (cdb_hits(m_qj[i])) begin m_vj[i] = cdb_data; m_qj[i] = 0; end
                if (cdb_hits(m_qk[i])) begin m_vk[i] = cdb_data; m_qk[i] = 0; end
            end else begin
                if (cdb_valid && cdb_tag == TAG_W'(BASE_TAG + i)) m_st[i] = 0;
            end
        end
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Compare process: outputs depend on registered state only, so the
    // falling edge is a safe sampling point.
    initial begin
        int fi;
        int si;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                fi = m_first_free();
                si = m_first_ready();
                chk("mdl_isFull", isFull, (fi < 0));
                if (fi >= 0) chk("mdl_issue_tag", issue_tag, BASE_TAG + fi);
                chk("mdl_exe_valid", exe_valid, (si >= 0));
                if (si >= 0) begin
                    chk("mdl_exe_op",  exe_op,  m_op[si]);
                    chk("mdl_exe_a",   exe_a,   m_vj[si]);
                    chk("mdl_exe_b",   exe_b,   m_vk[si]);
                    chk("mdl_exe_tag", exe_tag, BASE_TAG + si);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic idle();
        issue_en  = 1'b0;
        cdb_valid = 1'b0;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] vj, input logic [3:0] qj,
                         input logic [31:0] vk, input logic [3:0] qk);
        issue_en = 1'b1;
        issue_op = op;
        issue_vj = vj;
        issue_qj = qj;
        issue_vk = vk;
        issue_qk = qk;
    endtask

    task automatic bcast(input logic [3:0] tag, input logic [31:0] data);
        cdb_valid = 1'b1;
        cdb_tag   = tag;
        cdb_data  = data;
    endtask

    function automatic logic [3:0] pick_tag();
        int r;
        r = $urandom_range(0, 5);
        if (r < 2) return 4'd0;
        if (r == 5) return 4'd9;
        return 4'(r - 1);
    endfunction

    initial begin
        nRST = 1'b0; exe_ready = 1'b0;
        issue_en = 0; issue_op = 0; issue_vj = 0; issue_qj = 0; issue_vk = 0; issue_qk = 0;
        cdb_valid = 0; cdb_tag = 0; cdb_data = 0;
        cyc();
        chk_en = 1'b1;
        cyc();

        // Reset state
        chk("rst_isFull", isFull, 0);
        chk("rst_exe_valid", exe_valid, 0);
        chk("rst_issue_tag", issue_tag, 1);
        chk("rst_exe_op", exe_op, 0);
        chk("rst_exe_a", exe_a, 0);
        chk("rst_exe_b", exe_b, 0);
        chk("rst_exe_tag", exe_tag, 0);
        nRST = 1'b1;

        // Simple issue with both operands present
        exe_ready = 1'b1;
        issue(2'd0, 32'd5, 4'd0, 32'd7, 4'd0);
        cyc(); idle();
        chk("t1_valid", exe_valid, 1);
        chk("t1_a", exe_a, 5);
        chk("t1_b", exe_b, 7);
        chk("t1_tag", exe_tag, 1);
        chk("t1_issue_tag", issue_tag, 2);
        cyc();
        chk("t1_valid_after_acc", exe_valid, 0);
        chk("t1_isFull", isFull, 0);
        chk("t1_issue_tag_exec", issue_tag, 2);
        bcast(4'd1, 32'h99);
        cyc(); idle();
        chk("t1_freed_tag", issue_tag, 1);

        // Pending j operand resolved by a later broadcast
        issue(2'd1, 32'h77, 4'd5, 32'd3, 4'd0);
        cyc(); idle();
        cyc();
        cyc();
        chk("t2_wait_valid", exe_valid, 0);
        bcast(4'd5, 32'h10);
        cyc(); idle();
        chk("t2_valid", exe_valid, 1);
        chk("t2_a", exe_a, 32'h10);
        chk("t2_b", exe_b, 3);
        chk("t2_op", exe_op, 1);
        cyc();
        chk("t2_accepted", exe_valid, 0);
        bcast(4'd1, 32'h0);
        cyc(); idle();

        // Fill, ignore overflow, in-order dispatch, free a middle entry
        exe_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            issue(2'd2, 32'd0, 4'd9, 32'(i + 1), 4'd0);
            cyc();
        end
        chk("t3_full", isFull, 1);
        issue(2'd3, 32'h44, 4'd0, 32'h44, 4'd0);
        cyc(); idle();
        chk("t3_full_hold", isFull, 1);
        chk("t3_overflow_ignored", exe_valid, 0);
        exe_ready = 1'b1;
        bcast(4'd9, 32'h20);
        cyc(); idle();
        for (int i = 0; i < 3; i++) begin
            chk("t3_order_tag", exe_tag, i + 1);
            chk("t3_order_a", exe_a, 32'h20);
            chk("t3_order_b", exe_b, i + 1);
            cyc();
        end
        chk("t3_all_exec_valid", exe_valid, 0);
        chk("t3_all_exec_full", isFull, 1);
        exe_ready = 1'b0;
        bcast(4'd2, 32'h0);
        cyc(); idle();
        chk("t3_free_full", isFull, 0);
        chk("t3_free_tag", issue_tag, 2);
        bcast(4'd1, 32'h0);
        cyc();
        bcast(4'd3, 32'h0);
        cyc(); idle();
        chk("t3_all_free_tag", issue_tag, 1);

        // Issue-time bypass on k, then hold under backpressure
        issue(2'd3, 32'h11, 4'd0, 32'd0, 4'd6);
        bcast(4'd6, 32'hAB);
        cyc(); idle();
        chk("t4_valid", exe_valid, 1);
        chk("t4_b", exe_b, 32'hAB);
        chk("t4_a", exe_a, 32'h11);
        chk("t4_op", exe_op, 3);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("t5_hold_valid", exe_valid, 1);
            chk("t5_hold_a", exe_a, 32'h11);
            chk("t5_hold_tag", exe_tag, 1);
        end
        exe_ready = 1'b1;
        cyc();
        chk("t5_accepted", exe_valid, 0);
        cyc();
        chk("t5_accepted_once", exe_valid, 0);
        exe_ready = 1'b0;
        bcast(4'd1, 32'h0);
        cyc(); idle();

        // Reset with one EXEC and one BUSY entry
        issue(2'd0, 32'd1, 4'd0, 32'd2, 4'd0);
        cyc();
        issue(2'd0, 32'd3, 4'd0, 32'd4, 4'd0);
        cyc(); idle();
        exe_ready = 1'b1;
        cyc();
        exe_ready = 1'b0;
        chk("t6_pre_tag", exe_tag, 2);
        chk("t6_pre_issue_tag", issue_tag, 3);
        nRST = 1'b0;
        cyc();
        chk("t6_rst_full", isFull, 0);
        chk("t6_rst_valid", exe_valid, 0);
        chk("t6_rst_issue_tag", issue_tag, 1);
        nRST = 1'b1;
        bcast(4'd1, 32'h55);
        cyc(); idle();
        chk("t6_old_tag_full", isFull, 0);
        chk("t6_old_tag_issue_tag", issue_tag, 1);
        chk("t6_old_tag_valid", exe_valid, 0);

        // Mixed traffic with overlapping issue/snoop/dispatch/free
        for (int n = 0; n < 300; n++) begin
            issue_en  = ($urandom_range(0, 2) != 0);
            issue_op  = 2'($urandom_range(0, 3));
            issue_vj  = $urandom;
            issue_vk  = $urandom;
            issue_qj  = pick_tag();
            issue_qk  = pick_tag();
            cdb_valid = ($urandom_range(0, 1) == 1);
            cdb_tag   = pick_tag();
            cdb_data  = $urandom;
            exe_ready = ($urandom_range(0, 1) == 1);
            cyc();
        end
        idle();
        cyc();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
